// File: rtl/merge_pkg.sv
// merge_pkg: shared constants, types and helpers for the 4:1 ingress merger.
//   NUM_QUEUES / DATA_WIDTH / CTRL_WIDTH / FIFO_DEPTH : default geometry
//   port_id_t                                       : 2-bit source port number
//   SRC_LSB / SRC_MSB                               : source-port field in ctl
//   sat_add16()                                     : saturating drop-count add
package merge_pkg;

    localparam int NUM_QUEUES = 4;
    localparam int DATA_WIDTH = 480;
    localparam int CTRL_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    typedef logic [1:0] port_id_t;

    localparam int SRC_LSB = 0;
    localparam int SRC_MSB = 1;

    // Add a small increment to a 16-bit counter, clamping at 16'hFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {14'd0, inc};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

endpackage

// File: rtl/merge_fifo.sv
// merge_fifo: single-clock FIFO, one push and one pop per cycle.
//   clk, rst      : clock, synchronous active-high reset
//   push, wdata   : write request and word (ignored while full)
//   pop, rdata    : read request (ignored while empty) and head word
//   full, empty   : decoded from the registered occupancy count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module merge_fifo
    import merge_pkg::*;
#(
    parameter int WIDTH = CTRL_WIDTH + DATA_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; push+pop together leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/in_merge_point.sv
// in_merge_point: 4:1 ingress merger.
//   in_wr/in_ctl/in_data 0..3 : per-port word streams, each into its own FIFO
//   in_full0..3               : FIFO i holds FIFO_DEPTH words (writes dropped)
//   out_rdy                   : downstream accepts the current output word
//   out_wr0/out_ctl0/out_data0: registered merged stream; ctl[1:0] = source port
//   drop_cnt                  : saturating count of dropped words
module in_merge_point
    import merge_pkg::*;
#(
    parameter int DATA_WIDTH = merge_pkg::DATA_WIDTH,
    parameter int CTRL_WIDTH = merge_pkg::CTRL_WIDTH,
    parameter int NUM_QUEUES = merge_pkg::NUM_QUEUES,
    parameter int FIFO_DEPTH = merge_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_wr0,
    input  logic [CTRL_WIDTH-1:0] in_ctl0,
    input  logic [DATA_WIDTH-1:0] in_data0,
    output logic                  in_full0,
    input  logic                  in_wr1,
    input  logic [CTRL_WIDTH-1:0] in_ctl1,
    input  logic [DATA_WIDTH-1:0] in_data1,
    output logic                  in_full1,
    input  logic                  in_wr2,
    input  logic [CTRL_WIDTH-1:0] in_ctl2,
    input  logic [DATA_WIDTH-1:0] in_data2,
    output logic                  in_full2,
    input  logic                  in_wr3,
    input  logic [CTRL_WIDTH-1:0] in_ctl3,
    input  logic [DATA_WIDTH-1:0] in_data3,
    output logic                  in_full3,
    input  logic                  out_rdy,
    output logic                  out_wr0,
    output logic [CTRL_WIDTH-1:0] out_ctl0,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [15:0]           drop_cnt
);

    localparam int FW = CTRL_WIDTH + DATA_WIDTH;

    logic [NUM_QUEUES-1:0] wr_s, full_s, empty_s, pop_s;
    logic [FW-1:0]         wdata_s [NUM_QUEUES];
    logic [FW-1:0]         rdata_s [NUM_QUEUES];

    logic                  adv_s, found_s;
    port_id_t              grant_s, idx_s;
    logic [2:0]            drops_s;

    logic                  out_wr_q, out_wr_d;
    logic [CTRL_WIDTH-1:0] out_ctl_q, out_ctl_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    port_id_t              ptr_q, ptr_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    assign wr_s       = {in_wr3, in_wr2, in_wr1, in_wr0};
    assign wdata_s[0] = {in_ctl0, in_data0};
    assign wdata_s[1] = {in_ctl1, in_data1};
    assign wdata_s[2] = {in_ctl2, in_data2};
    assign wdata_s[3] = {in_ctl3, in_data3};

    for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
        merge_fifo #(
            .WIDTH(FW),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (wr_s[g]),
            .wdata(wdata_s[g]),
            .pop  (pop_s[g]),
            .rdata(rdata_s[g]),
            .full (full_s[g]),
            .empty(empty_s[g])
        );
    end

    assign in_full0  = full_s[0];
    assign in_full1  = full_s[1];
    assign in_full2  = full_s[2];
    assign in_full3  = full_s[3];
    assign out_wr0   = out_wr_q;
    assign out_ctl0  = out_ctl_q;
    assign out_data0 = out_data_q;
    assign drop_cnt  = drop_cnt_q;

    // Round-robin search starting one past the last grant (k=4 wraps to ptr itself).
    always_comb begin
        found_s = 1'b0;
        grant_s = ptr_q;
        idx_s   = ptr_q;
        for (int k = 1; k <= 4; k++) begin
            idx_s = ptr_q + port_id_t'(k);
            if (!found_s && !empty_s[idx_s]) begin
                found_s = 1'b1;
                grant_s = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Output register advance, pop selection and pointer update.
    always_comb begin
        adv_s      = !out_wr_q || out_rdy;
        pop_s      = {NUM_QUEUES{1'b0}};
        out_wr_d   = out_wr_q;
        out_ctl_d  = out_ctl_q;
        out_data_d = out_data_q;
        ptr_d      = ptr_q;
        if (adv_s && found_s) begin
            pop_s[grant_s] = 1'b1;
            out_wr_d       = 1'b1;
            out_ctl_d      = rdata_s[grant_s][FW-1:DATA_WIDTH];
            out_ctl_d[SRC_MSB:SRC_LSB] = grant_s;
            out_data_d     = rdata_s[grant_s][DATA_WIDTH-1:0];
            ptr_d          = grant_s;
        end else if (adv_s) begin
            out_wr_d = 1'b0;
        end else begin
            out_wr_d = out_wr_q;
        end
    end

    // Drops use the registered full flag, so a same-cycle pop cannot rescue a write.
    always_comb begin
        drops_s = 3'd0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            drops_s = drops_s + {2'b00, wr_s[i] && full_s[i]};
        end
        drop_cnt_d = sat_add16(drop_cnt_q, drops_s);
    end

    // Output, arbiter pointer and drop counter registers; ptr resets to 3 so port 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_wr_q   <= 1'b0;
            out_ctl_q  <= {CTRL_WIDTH{1'b0}};
            out_data_q <= {DATA_WIDTH{1'b0}};
            ptr_q      <= 2'd3;
            drop_cnt_q <= 16'd0;
        end else begin
            out_wr_q   <= out_wr_d;
            out_ctl_q  <= out_ctl_d;
            out_data_q <= out_data_d;
            ptr_q      <= ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_in_merge_point.sv
// tb_in_merge_point: directed self-checking bench for in_merge_point.
module tb_in_merge_point;

    localparam int DW = 480;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          wr   [4];
    logic [CW-1:0] ctl  [4];
    logic [DW-1:0] data [4];
    logic          full [4];
    logic          out_rdy;
    logic          out_wr0;
    logic [CW-1:0] out_ctl0;
    logic [DW-1:0] out_data0;
    logic [15:0]   drop_cnt;

    int n_checks;
    int n_pass;

    in_merge_point dut (
        .clk(clk), .rst(rst),
        .in_wr0(wr[0]), .in_ctl0(ctl[0]), .in_data0(data[0]), .in_full0(full[0]),
        .in_wr1(wr[1]), .in_ctl1(ctl[1]), .in_data1(data[1]), .in_full1(full[1]),
        .in_wr2(wr[2]), .in_ctl2(ctl[2]), .in_data2(data[2]), .in_full2(full[2]),
        .in_wr3(wr[3]), .in_ctl3(ctl[3]), .in_data3(data[3]), .in_full3(full[3]),
        .out_rdy(out_rdy), .out_wr0(out_wr0), .out_ctl0(out_ctl0),
        .out_data0(out_data0), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word j of port p as written: low ctl bits deliberately 2'b11 so replacement is visible.
    function automatic logic [CW-1:0] in_ctl_of(input int p, input int j);
        return 32'h0000_0A03 + (p << 8) + (j << 4);
    endfunction
    function automatic logic [CW-1:0] exp_ctl_of(input int p, input int j);
        logic [CW-1:0] c;
        c = in_ctl_of(p, j);
        c[1:0] = p[1:0];
        return c;
    endfunction
    function automatic logic [DW-1:0] data_of(input int p, input int j);
        return DW'(32'h00C0_0000 + (p << 8) + j);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            wr[p] = 1'b0; ctl[p] = '0; data[p] = '0;
        end
    endtask

    task automatic drive(input int p, input int j);
        wr[p] = 1'b1; ctl[p] = in_ctl_of(p, j); data[p] = data_of(p, j);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_rdy = 1'b1;
        rst = 1'b1;
        for (int p = 0; p < 4; p++) drive(p, 0);
        tick(); tick(); tick();
        n_checks++;
        if ({out_wr0, drop_cnt} !== 17'd0)
            $display("FAIL reset_out: out_wr0/drop_cnt=%h expected 0", {out_wr0, drop_cnt});
        else n_pass++;
        n_checks++;
        if ({full[3], full[2], full[1], full[0]} !== 4'b0000)
            $display("FAIL reset_full: in_full=%b expected 0000", {full[3], full[2], full[1], full[0]});
        else n_pass++;
        clear_inputs();
        rst = 1'b0;
        tick();
        drive(3, 0); drive(0, 0);
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if ({out_wr0, out_ctl0, out_data0} !== {1'b1, exp_ctl_of(0, 0), data_of(0, 0)})
            $display("FAIL reset_first_grant: ctl=%h expected %h", out_ctl0, exp_ctl_of(0, 0));
        else n_pass++;
        tick();
        n_checks++;
        if ({out_wr0, out_ctl0, out_data0} !== {1'b1, exp_ctl_of(3, 0), data_of(3, 0)})
            $display("FAIL reset_second_grant: ctl=%h expected %h", out_ctl0, exp_ctl_of(3, 0));
        else n_pass++;
        tick();
        n_checks++;
        if (out_wr0 !== 1'b0)
            $display("FAIL reset_idle: out_wr0=%b expected 0", out_wr0);
        else n_pass++;
    endtask

    task automatic test_single_word();
        do_reset();
        out_rdy = 1'b1;
        tick(); tick(); tick(); tick();
        wr[2] = 1'b1; ctl[2] = 32'h0000_0010; data[2] = DW'(32'hAB);
        tick();
        clear_inputs();
        n_checks++;
        if (out_wr0 !== 1'b0)
            $display("FAIL single_n1: out_wr0=%b expected 0", out_wr0);
        else n_pass++;
        tick();
        n_checks++;
        if ({out_wr0, out_ctl0, out_data0} !== {1'b1, 32'h0000_0012, DW'(32'hAB)})
            $display("FAIL single_n2: wr=%b ctl=%h data=%h expected 1 00000012 ab",
                     out_wr0, out_ctl0, out_data0[31:0]);
        else n_pass++;
        tick();
        n_checks++;
        if (out_wr0 !== 1'b0)
            $display("FAIL single_after: out_wr0=%b expected 0", out_wr0);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            if (c < 3) begin
                for (int p = 0; p < 4; p++) drive(p, c);
            end else begin
                clear_inputs();
            end
            tick();
            if (c >= 1) begin
                n_checks++;
                if ({out_wr0, out_ctl0, out_data0} !== {1'b1, exp_ctl_of((c-1)%4, (c-1)/4), data_of((c-1)%4, (c-1)/4)})
                    $display("FAIL rr_word%0d: wr=%b ctl=%h expected 1 %h", c-1, out_wr0, out_ctl0,
                             exp_ctl_of((c-1)%4, (c-1)/4));
                else n_pass++;
            end
        end
        tick();
        n_checks++;
        if ({out_wr0, drop_cnt} !== 17'd0)
            $display("FAIL rr_end: wr/drop=%h expected 0", {out_wr0, drop_cnt});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        out_rdy = 1'b0;
        for (int j = 0; j < 6; j++) begin
            drive(1, j);
            tick();
            if (j == 3) begin
                n_checks++;
                if (full[1] !== 1'b0) $display("FAIL bp_not_full_yet: in_full1=%b expected 0", full[1]);
                else n_pass++;
            end
            if (j == 4) begin
                n_checks++;
                if (full[1] !== 1'b1) $display("FAIL bp_full_rise: in_full1=%b expected 1", full[1]);
                else n_pass++;
            end
        end
        clear_inputs();
        n_checks++;
        if (drop_cnt !== 16'd1) $display("FAIL bp_drop1: drop_cnt=%0d expected 1", drop_cnt);
        else n_pass++;
        tick(); tick();
        n_checks++;
        if ({out_wr0, out_ctl0, out_data0, full[1]} !== {1'b1, exp_ctl_of(1, 0), data_of(1, 0), 1'b1})
            $display("FAIL bp_hold: wr=%b ctl=%h full=%b expected 1 %h 1", out_wr0, out_ctl0, full[1], exp_ctl_of(1, 0));
        else n_pass++;
        // Release with a write to the still-full FIFO: the pop must not save it.
        out_rdy = 1'b1;
        drive(1, 9);
        tick();
        clear_inputs();
        n_checks++;
        if ({out_ctl0, drop_cnt, full[1]} !== {exp_ctl_of(1, 1), 16'd2, 1'b0})
            $display("FAIL bp_release: ctl=%h drop=%0d full=%b expected %h 2 0",
                     out_ctl0, drop_cnt, full[1], exp_ctl_of(1, 1));
        else n_pass++;
        for (int j = 2; j < 5; j++) begin
            tick();
            n_checks++;
            if ({out_wr0, out_ctl0, out_data0} !== {1'b1, exp_ctl_of(1, j), data_of(1, j)})
                $display("FAIL bp_drain%0d: wr=%b ctl=%h expected 1 %h", j, out_wr0, out_ctl0, exp_ctl_of(1, j));
            else n_pass++;
        end
        tick();
        n_checks++;
        if (out_wr0 !== 1'b0) $display("FAIL bp_empty: out_wr0=%b expected 0", out_wr0);
        else n_pass++;
    endtask

    task automatic test_push_pop();
        do_reset();
        out_rdy = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            if (c < 8) drive(0, c);
            else clear_inputs();
            tick();
            if (c >= 1) begin
                n_checks++;
                if ({out_wr0, out_ctl0, out_data0} !== {1'b1, exp_ctl_of(0, c-1), data_of(0, c-1)})
                    $display("FAIL stream_word%0d: wr=%b ctl=%h expected 1 %h", c-1, out_wr0, out_ctl0, exp_ctl_of(0, c-1));
                else n_pass++;
            end
        end
        n_checks++;
        if ({full[0], drop_cnt} !== 17'd0)
            $display("FAIL stream_nodrop: full/drop=%h expected 0", {full[0], drop_cnt});
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_rdy = 1'b0;
        for (int j = 0; j < 6; j++) begin
            for (int p = 0; p < 4; p++) drive(p, j);
            tick();
            if (j == 4) begin
                n_checks++;
                if (drop_cnt !== 16'd3) $display("FAIL multi_drop3: drop_cnt=%0d expected 3", drop_cnt);
                else n_pass++;
            end
        end
        clear_inputs();
        n_checks++;
        if ({drop_cnt, full[3], full[2], full[1], full[0]} !== {16'd7, 4'b1111})
            $display("FAIL multi_drop7: drop=%0d full=%b expected 7 1111", drop_cnt,
                     {full[3], full[2], full[1], full[0]});
        else n_pass++;
        rst = 1'b1;
        for (int p = 0; p < 4; p++) drive(p, 7);
        tick();
        rst = 1'b0;
        clear_inputs();
        n_checks++;
        if ({out_wr0, out_ctl0, out_data0, drop_cnt, full[3], full[2], full[1], full[0]} !== '0)
            $display("FAIL midrst_clear: wr=%b ctl=%h drop=%0d full=%b expected all 0", out_wr0, out_ctl0,
                     drop_cnt, {full[3], full[2], full[1], full[0]});
        else n_pass++;
        out_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            n_checks++;
            if (out_wr0 !== 1'b0) $display("FAIL midrst_stale%0d: out_wr0=%b expected 0", c, out_wr0);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        out_rdy  = 1'b0;
        clear_inputs();
        test_reset();
        test_single_word();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/in_merge_point.md
# in_merge_point

4:1 ingress merger: collects packet words from four per-port streams into a single output stream feeding the match-action stages. Each input has its own small FIFO; a round-robin arbiter drains one word per cycle into a registered output. The source port number is written into `ctl[1:0]`, so the downstream 1:4 egress switch can route on that field.

## Interface
Parameters:
- `DATA_WIDTH`, 480: data word width
- `CTRL_WIDTH`, 32: control word width, ≥ 2
- `NUM_QUEUES`, 4: input port count, fixed at 4
- `FIFO_DEPTH`, 4: words per input FIFO, power of two

Ports:
- `clk`  in  1: single clock
- `rst`  in  1: reset; synchronous and active-high
- `in_wr0..3`  in  1: word valid on port i
- `in_ctl0..3`  in  CTRL_WIDTH: control word, port i
- `in_data0..3`  in  DATA_WIDTH: data word, port i
- `in_full0..3`  out  1: FIFO i holds FIFO_DEPTH words
- `out_rdy`  in  1: downstream accepts the current output word
- `out_wr0`  out  1: output word valid
- `out_ctl0`  out  CTRL_WIDTH: `{ctl[CTRL_WIDTH-1:2], src_port[1:0]}`
- `out_data0`  out  DATA_WIDTH: data, passed unchanged
- `drop_cnt`  out  16: saturating count of words dropped on full FIFOs

## Operation
- Reset (sampled at `posedge clk` while `rst`=1): all FIFOs empty; `out_wr0`=0, `out_ctl0`=0, `out_data0`=0, `in_full*`=0, `drop_cnt`=0, RR pointer=3, so port 0 has first priority.
- Write: `in_wr_i`=1 and count_i<FIFO_DEPTH: push `{ctl,data}`. Write while count_i==FIFO_DEPTH: drop the word and increment `drop_cnt` (saturates at 0xFFFF). The full test uses the registered count only. A write to a full FIFO is dropped even if that FIFO pops in the same cycle.
- Multiple ports may write in the same cycle; each FIFO is independent. Drops on k ports in one cycle add k to `drop_cnt`, saturating.
- Output register advance condition: `adv = !out_wr0 || out_rdy`.
- When `adv` is true:
  - Grant the first non-empty FIFO, searching from ptr+1 mod 4 upward.
  - Pop it, load the output registers, set `out_wr0`=1, and set ptr to the granted port.
  - If no FIFO is non-empty, set `out_wr0`=0. `out_ctl0`/`out_data0` hold their last values.
- When `adv` is false (`out_wr0`=1, `out_rdy`=0): no pop; outputs hold; ptr holds.
- Pop and push on the same FIFO in the same cycle (not full): both take effect and the count is unchanged.
- Push to an empty FIFO is not visible to the arbiter until the next cycle; there is no fall-through.
- Per-port word order is preserved. No packet-boundary awareness: words from different ports may interleave.
- Reset asserted mid-operation discards all FIFO contents and the output word on that edge. Inputs during reset are ignored.

## Timing
- Latency: `in_wr_i` high in cycle n, FIFO i empty, no contention → `out_wr0` high in cycle n+2.
- Throughput: 1 word/cycle while `out_rdy`=1.
- `in_full_i` rises in the cycle after the write that fills the FIFO. It falls in the cycle after the pop that frees a slot.
- Fairness: with all four ports backlogged, grants follow 0,1,2,3,0,… and each port gets exactly 1 of every 4 words.
- `drop_cnt` updates in the cycle after the dropped write.

## Structure
- Shared package `merge_pkg`:
  - NUM_QUEUES, widths, FIFO_DEPTH
  - `port_id_t` (2-bit)
  - `SRC_LSB`=0, `SRC_MSB`=1: location of the source-port field in ctl
- Sub-module `merge_fifo`:
  - sync FIFO, width CTRL_WIDTH+DATA_WIDTH
  - count register, `full`/`empty`, push/pop
  - instantiated 4 times
- Top level holds the RR arbiter, output register, and drop counter.

## Test plan
- Reset: drive `in_wr*`=1 with `rst`=1 → `out_wr0`=0, `drop_cnt`=0, `in_full*`=0. First grant after release goes to port 0.
- Single word: port 2 writes ctl=0x0000_0010, data=0xAB at cycle 5 → cycle 7 `out_wr0`=1, `out_ctl0`=0x0000_0012, `out_data0`=0xAB.
- Round robin: all four ports write 3 words each in cycles 0–2, `out_rdy`=1 → 12 outputs in sources 0,1,2,3 ×3, in per-port order, no gaps.
- Backpressure/full: `out_rdy`=0, port 1 writes 6 words → `out_wr0` holds the first word, `in_full1`=1, 1 word dropped, `drop_cnt`=1. Release `out_rdy` → the 5 accepted words emerge in order.
- Simultaneous push/pop: port 0 streams one word per cycle with `out_rdy`=1 → steady 1 word/cycle, FIFO count constant, no drops.
- Mid-operation reset: pulse `rst` with words queued on all ports → next cycle `out_wr0`=0, all FIFOs empty, and no stale word is ever emitted.
